// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller slice.
package mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Counter preload for an access held for 'cycles' cycles (counter runs N-1 .. 0).
  function automatic logic [CNT_WIDTH-1:0] wait_load(input int cycles);
    return CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter; done_o is high whenever the count reads zero.
module wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller: holds address/data/strobe for a
// fixed number of cycles per access, returns read data through a response
// channel and pulses wr_done_o when a write completes.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. req_ready_o depends on state only,
// and rsp_valid_o/rsp_data_o stay stable until the response transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_WAIT_CYCLES = 5000,
  parameter int WR_WAIT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] req_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RAM_DATA_WIDTH-1:0] rsp_data_o,
  output logic                      wr_done_o,
  output logic                      mem_wr_o,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] mem_data_o,
  input  logic [RAM_DATA_WIDTH-1:0] mem_data_i,
  output state_e                    dbg_state_o
);

  localparam logic [CNT_WIDTH-1:0] RD_LOAD = wait_load(RD_WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WR_LOAD = wait_load(WR_WAIT_CYCLES);

  state_e                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                      mem_wr_q, mem_wr_d;
  logic [RAM_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      wr_done_q, wr_done_d;

  logic                      cnt_load;
  logic [CNT_WIDTH-1:0]      cnt_load_val;
  logic                      cnt_en;
  logic                      cnt_done;

  wait_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_wait_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .done_o    (cnt_done)
  );

  // Next-state and datapath: mem_wr_q doubles as the operation type during ACCESS.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mem_wr_d     = mem_wr_q;
    rsp_data_d   = rsp_data_q;
    wr_done_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d       = req_addr_i;
          data_d       = req_data_i;
          mem_wr_d     = req_wr_i;
          cnt_load     = 1'b1;
          cnt_load_val = req_wr_i ? WR_LOAD : RD_LOAD;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_done) begin
          mem_wr_d = 1'b0;
          if (mem_wr_q) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            rsp_data_d = mem_data_i;
            state_d    = RESP;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      mem_wr_q   <= 1'b0;
      rsp_data_q <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mem_wr_q   <= mem_wr_d;
      rsp_data_q <= rsp_data_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign wr_done_o   = wr_done_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with RD=4 / WR=8 and a memory model that only
// commits a write after the strobe has been held the full write time.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RD = 4;
  localparam int WR = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          wr_done;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  state_e        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  mem_ctrl #(
    .RAM_DATA_WIDTH(DW),
    .RAM_ADDR_WIDTH(AW),
    .RD_WAIT_CYCLES(RD),
    .WR_WAIT_CYCLES(WR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_wr_i   (req_wr),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .wr_done_o  (wr_done),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: contents f(addr) after reset; write commits on the WR-th strobe cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_cyc;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i) ^ 16'h5A00;
      wr_cyc <= 0;
    end else if (mem_wr) begin
      if (wr_cyc == WR - 1) mem[mem_addr] <= mem_wdata;
      wr_cyc <= wr_cyc + 1;
    end else begin
      wr_cyc <= 0;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle forward; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write with hand-timed checks; returns in cycle T+9 (wr_done cycle).
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_data = d;
    check("wr_accept_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= WR; i++) begin
      check("wr_strobe", 32'(mem_wr), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'(a));
      check("wr_data", 32'(mem_wdata), 32'(d));
      check("wr_ready_low", 32'(req_ready), 32'd0);
      check("wr_done_early", 32'(wr_done), 32'd0);
      tick();
    end
    check("wr_strobe_off", 32'(mem_wr), 32'd0);
    check("wr_done_pulse", 32'(wr_done), 32'd1);
    check("wr_ready_back", 32'(req_ready), 32'd1);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  // Read with response held off for 'hold' cycles while requests are attempted.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_data = 16'h0;
    check("rd_accept_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= RD; i++) begin
      check("rd_addr", 32'(mem_addr), 32'(a));
      check("rd_no_strobe", 32'(mem_wr), 32'd0);
      check("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_data", 32'(rsp_data), 32'(exp));
    check("rd_no_wr_done", 32'(wr_done), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = (i % 2 == 0); req_wr = 1'b1; req_addr = 10'h020; req_data = 16'h1111;
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp));
      check("hold_no_accept", 32'(req_ready), 32'd0);
      check("hold_no_strobe", 32'(mem_wr), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_rsp_drop", 32'(rsp_valid), 32'd0);
    check("rd_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    tick();

    // Write BEEF to 0x012, then read it back with a 10-cycle response stall.
    do_write(10'h012, 16'hBEEF);
    tick();
    check("wr_done_one_cycle", 32'(wr_done), 32'd0);
    check("idle_addr_hold", 32'(mem_addr), 32'h012);
    do_read(10'h012, 16'hBEEF, 10);
    // Pulsed requests during the stall must not have reached memory.
    tick();
    do_read(10'h020, 16'h5A20, 0);
    check("rsp_ready_ignored", 32'(rsp_valid), 32'd0);

    // Back-to-back writes with valid held high.
    tick();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h030; req_data = 16'h1234;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    tick();
    req_addr = 10'h031; req_data = 16'h5678;
    for (int i = 1; i <= WR; i++) begin
      check("b2b_first_strobe", 32'(mem_wr), 32'd1);
      check("b2b_first_addr", 32'(mem_addr), 32'h030);
      tick();
    end
    check("b2b_gap_strobe", 32'(mem_wr), 32'd0);
    check("b2b_gap_done", 32'(wr_done), 32'd1);
    check("b2b_gap_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= WR; i++) begin
      check("b2b_second_strobe", 32'(mem_wr), 32'd1);
      check("b2b_second_addr", 32'(mem_addr), 32'h031);
      check("b2b_second_data", 32'(mem_wdata), 32'h5678);
      tick();
    end
    check("b2b_second_done", 32'(wr_done), 32'd1);
    tick();
    do_read(10'h030, 16'h1234, 0);
    tick();

    // Reset in cycle T+3 of a write.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h040; req_data = 16'hDEAD;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("abort_strobe_before", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_strobe_async", 32'(mem_wr), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_no_done", 32'(wr_done), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < WR + 2; i++) begin
      check("abort_quiet_done", 32'(wr_done), 32'd0);
      check("abort_quiet_rsp", 32'(rsp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      tick();
    end
    do_read(10'h040, 16'h5A40, 0);
    tick();

    // Maximum address.
    do_read(10'h3FF, 16'h59FF, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_DATA_WIDTH, default 16, memory word width.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have parameter RD_WAIT_CYCLES, default 5000, cycles the memory address is held for a read (legal range 2..65535).
REQ-004 SHALL have parameter WR_WAIT_CYCLES, default 65535, cycles address, data and write strobe are held for a write (legal range 2..65535).
REQ-005 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port req_valid_i  input  1  request present.
REQ-008 SHALL have port req_ready_o  output  1  controller accepts a request this cycle.
REQ-009 SHALL have port req_wr_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr_i  input  RAM_ADDR_WIDTH  request address.
REQ-011 SHALL have port req_data_i  input  RAM_DATA_WIDTH  write data.
REQ-012 SHALL have port rsp_valid_o  output  1  read data available.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer takes read data.
REQ-014 SHALL have port rsp_data_o  output  RAM_DATA_WIDTH  read data.
REQ-015 SHALL have port wr_done_o  output  1  one-cycle pulse on write completion.
REQ-016 SHALL have port mem_wr_o  output  1  memory write strobe.
REQ-017 SHALL have port mem_addr_o  output  RAM_ADDR_WIDTH  memory address.
REQ-018 SHALL have port mem_data_o  output  RAM_DATA_WIDTH  memory write data.
REQ-019 SHALL have port mem_data_i  input  RAM_DATA_WIDTH  memory read data.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-021 SHALL drive req_ready_o = 1 only in IDLE, decoded from state only, with no dependence on req_valid_i.
REQ-022 SHALL accept a request in cycle T when req_valid_i and req_ready_o are both 1, and register the address, data and operation; IDLE->ACCESS.
REQ-023 SHALL drive mem_addr_o, mem_data_o and mem_wr_o (mem_wr_o = req_wr_i) from registers, stable for cycles T+1 through T+N inclusive, N = RD_WAIT_CYCLES for reads and WR_WAIT_CYCLES for writes.
REQ-024 SHALL count the wait with a down-counter: load N-1 on accept, decrement each ACCESS cycle, and leave ACCESS on the cycle the counter reads 0.
REQ-025 SHALL on a write deassert mem_wr_o in cycle T+N+1, pulse wr_done_o high for exactly cycle T+N+1, and go ACCESS->IDLE (req_ready_o = 1 in T+N+1).
REQ-026 SHALL on a read sample mem_data_i into rsp_data_o at the clock edge that ends cycle T+N, and go ACCESS->RESP with rsp_valid_o = 1 from T+N+1.
REQ-027 SHALL in RESP hold rsp_valid_o and rsp_data_o stable until rsp_ready_i = 1, then go RESP->IDLE (rsp_valid_o = 0 in the next cycle).
REQ-028 SHALL hold mem_addr_o and mem_data_o at their last values outside ACCESS, with mem_wr_o = 0 outside ACCESS.
REQ-029 SHALL ignore req_valid_i outside IDLE; no request is queued.
REQ-030 SHALL ignore rsp_ready_i when rsp_valid_o = 0.
REQ-031 SHALL never have rsp_valid_o and wr_done_o high in the same cycle.

Reset
REQ-032 SHALL on rst_i = 1 immediately force state IDLE, counter 0, mem_wr_o 0, mem_addr_o 0, mem_data_o 0, rsp_valid_o 0, rsp_data_o 0, wr_done_o 0; req_ready_o = 1 follows from IDLE.
REQ-033 SHALL on reset mid-ACCESS or mid-RESP abandon the transaction, dropping mem_wr_o asynchronously and producing no response or wr_done_o.

Structure
REQ-034 SHALL take the state enum type and the default width constants from shared package mem_ctrl_pkg.
REQ-035 SHALL implement the wait as sub-module wait_counter (load, count-enable, done flag) sized to 16 bits.

Verification (RD_WAIT_CYCLES = 4, WR_WAIT_CYCLES = 8, memory model with delays scaled to fit)
REQ-036 SHALL cover: write addr 0x012 data 0xBEEF accepted at T -> mem_wr_o = 1 in T+1..T+8 with mem_addr_o = 0x012 and mem_data_o = 0xBEEF; wr_done_o pulse at T+9; req_ready_o = 1 at T+9.
REQ-037 SHALL cover: read addr 0x012 after REQ-036 -> rsp_valid_o = 1 at T+5 with rsp_data_o = 0xBEEF.
REQ-038 SHALL cover: rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and rsp_data_o stable throughout; req_valid_i pulses in that window are not accepted.
REQ-039 SHALL cover: back-to-back writes with req_valid_i held 1 -> second write accepted in the wr_done_o cycle; mem_wr_o low exactly one cycle between the two writes.
REQ-040 SHALL cover: rst_i asserted at T+3 of a write -> mem_wr_o = 0 in the same cycle, no wr_done_o, req_ready_o = 1 after release; a read of that address returns pre-write data or X.
REQ-041 SHALL cover: read of addr 0x3FF (max) -> mem_addr_o = 0x3FF with no wrap or truncation.
